// File: rtl/dac_lin_upsampler.sv
// Linear-interpolation upsampler: reads one FIFO sample every 2^RATE_LOG2 clocks and ramps between
// consecutive samples at the clock rate. Define INTERP_ROUND_EN for round-half-up instead of floor.
module dac_lin_upsampler #(
   parameter int DATA_WIDTH = 14,
   parameter int RATE_LOG2  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fifo_almost_full,
   input  logic                         fifo_empty,
   output logic                         rd_en,
   input  logic signed [DATA_WIDTH-1:0] dataIn,
   output logic signed [DATA_WIDTH-1:0] inter_data,
   output logic                         out_valid,
   output logic                         underrun
);

   localparam int AW = DATA_WIDTH + RATE_LOG2 + 1;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] PRIME_A = 3'd1;
   localparam logic [2:0] PRIME_B = 3'd2;
   localparam logic [2:0] PRIME_C = 3'd3;
   localparam logic [2:0] RUN     = 3'd4;

   localparam logic [RATE_LOG2-1:0] PH_ONE  = RATE_LOG2'(1'b1);
   localparam logic [RATE_LOG2-1:0] PH_LAST = {RATE_LOG2{1'b1}};
   localparam logic [RATE_LOG2-1:0] PH_RD   = PH_LAST - PH_ONE;

`ifdef INTERP_ROUND_EN
   localparam logic signed [AW-1:0] ACC_HALF = AW'(1'b1) << (RATE_LOG2 - 1);
`endif

   logic [2:0]                  state_q, state_d;
   logic signed [DATA_WIDTH-1:0] prev_q, prev_d;
   logic signed [DATA_WIDTH-1:0] cur_q, cur_d;
   logic signed [DATA_WIDTH:0]   delta_q, delta_d;
   logic signed [AW-1:0]         acc_q, acc_d;
   logic [RATE_LOG2-1:0]         phase_q, phase_d;
   logic                         pend_q, pend_d;
   logic                         underrun_q, underrun_d;
   logic signed [DATA_WIDTH-1:0] inter_data_q, inter_data_d;
   logic                         out_valid_q, out_valid_d;
   logic                         rd_en_s;

   // Next-state logic for the sequencer and the interpolation datapath.
   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      cur_d      = cur_q;
      delta_d    = delta_q;
      acc_d      = acc_q;
      phase_d    = phase_q;
      pend_d     = pend_q;
      underrun_d = underrun_q;
      rd_en_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (fifo_almost_full) begin
               state_d = PRIME_A;
            end else begin
               state_d = IDLE;
            end
         end
         PRIME_A: begin
            rd_en_s = 1'b1;
            state_d = PRIME_B;
         end
         PRIME_B: begin
            rd_en_s = 1'b1;
            cur_d   = dataIn;
            state_d = PRIME_C;
         end
         PRIME_C: begin
            prev_d  = cur_q;
            cur_d   = dataIn;
            delta_d = {dataIn[DATA_WIDTH-1], dataIn} - {cur_q[DATA_WIDTH-1], cur_q};
            acc_d   = {cur_q[DATA_WIDTH-1], cur_q, {RATE_LOG2{1'b0}}};
            phase_d = '0;
            pend_d  = 1'b0;
            state_d = RUN;
         end
         RUN: begin
            acc_d   = acc_q + {{RATE_LOG2{delta_q[DATA_WIDTH]}}, delta_q};
            phase_d = phase_q + PH_ONE;
            // The refill read is only ever issued against a non-empty FIFO.
            if (phase_q == PH_RD) begin
               rd_en_s = ~fifo_empty;
               pend_d  = ~fifo_empty;
            end else begin
               rd_en_s = 1'b0;
            end
            if (phase_q == PH_LAST) begin
               if (pend_q) begin
                  prev_d  = cur_q;
                  cur_d   = dataIn;
                  delta_d = {dataIn[DATA_WIDTH-1], dataIn} - {cur_q[DATA_WIDTH-1], cur_q};
                  acc_d   = {cur_q[DATA_WIDTH-1], cur_q, {RATE_LOG2{1'b0}}};
                  phase_d = '0;
                  pend_d  = 1'b0;
               end else begin
                  underrun_d = 1'b1;
                  state_d    = IDLE;
               end
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output stage: sample rescaled from the accumulator, held outside RUN.
   always_comb begin
      out_valid_d = (state_q == RUN);
      if (state_q == RUN) begin
`ifdef INTERP_ROUND_EN
         inter_data_d = DATA_WIDTH'((acc_q + ACC_HALF) >>> RATE_LOG2);
`else
         inter_data_d = DATA_WIDTH'(acc_q >>> RATE_LOG2);
`endif
      end else begin
         inter_data_d = inter_data_q;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         prev_q       <= '0;
         cur_q        <= '0;
         delta_q      <= '0;
         acc_q        <= '0;
         phase_q      <= '0;
         pend_q       <= 1'b0;
         underrun_q   <= 1'b0;
         inter_data_q <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         cur_q        <= cur_d;
         delta_q      <= delta_d;
         acc_q        <= acc_d;
         phase_q      <= phase_d;
         pend_q       <= pend_d;
         underrun_q   <= underrun_d;
         inter_data_q <= inter_data_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign rd_en      = rd_en_s;
   assign inter_data = inter_data_q;
   assign out_valid  = out_valid_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_lin_upsampler.sv
// Scoreboard bench for dac_lin_upsampler: one instance at RATE_LOG2=4, one at RATE_LOG2=1,
// each fed by a small non-FWFT FIFO model. Expected ramps are queued as stimulus is issued.
module tb_dac_lin_upsampler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst4, af4, rd4, ov4, ur4;
   logic               rst1, af1, rd1, ov1, ur1;
   logic               empty4, empty1;
   logic signed [13:0] din4 = '0, din1 = '0;
   logic signed [13:0] id4, id1;

   dac_lin_upsampler #(.DATA_WIDTH(14), .RATE_LOG2(4)) dut4 (
      .clk(clk), .rst(rst4), .fifo_almost_full(af4), .fifo_empty(empty4), .rd_en(rd4),
      .dataIn(din4), .inter_data(id4), .out_valid(ov4), .underrun(ur4));

   dac_lin_upsampler #(.DATA_WIDTH(14), .RATE_LOG2(1)) dut1 (
      .clk(clk), .rst(rst1), .fifo_almost_full(af1), .fifo_empty(empty1), .rd_en(rd1),
      .dataIn(din1), .inter_data(id1), .out_valid(ov1), .underrun(ur1));

   // FIFO models: stimulus owns the write pointers, the read processes own the read pointers.
   logic signed [13:0] f4_mem [0:63];
   logic signed [13:0] f1_mem [0:63];
   int f4_wr = 0, f4_rd = 0, f1_wr = 0, f1_rd = 0;
   assign empty4 = (f4_rd == f4_wr);
   assign empty1 = (f1_rd == f1_wr);

   always @(posedge clk) begin
      if (rd4 && (f4_rd != f4_wr)) begin
         din4  <= f4_mem[f4_rd];
         f4_rd <= f4_rd + 1;
      end
   end

   always @(posedge clk) begin
      if (rd1 && (f1_rd != f1_wr)) begin
         din1  <= f1_mem[f1_rd];
         f1_rd <= f1_rd + 1;
      end
   end

   // Scoreboards: written by stimulus (e*_wr), consumed by the monitor (e*_rd).
   int e4_mem [0:255];
   int e1_mem [0:63];
   int e4_wr = 0, e4_rd = 0, e1_wr = 0, e1_rd = 0;
   int rd_cnt4 = 0, rd_cnt1 = 0;

   int n_chk = 0, n_pass = 0;

`ifdef INTERP_ROUND_EN
   int neg_tab [0:15] = '{0, 0, 0, -1, -1, -1, -1, -1, -1, -2, -2, -2, -2, -2, -3, -3};
`else
   int neg_tab [0:15] = '{0, -1, -1, -1, -1, -1, -2, -2, -2, -2, -2, -3, -3, -3, -3, -3};
`endif

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // prev + k*(cur-prev)/N, floored (or rounded half-up) in exact integer arithmetic.
   function automatic int model(input int p, input int c, input int k, input int r);
      int n, num, q;
      n   = 1 << r;
      num = p * n + k * (c - p);
`ifdef INTERP_ROUND_EN
      num = num + n / 2;
`endif
      q = num / n;
      if ((num % n) != 0 && num < 0) q = q - 1;
      return q;
   endfunction

   task automatic add_sample(input bit w, input int v);
      if (w) begin f1_mem[f1_wr] = v[13:0]; f1_wr++; end
      else   begin f4_mem[f4_wr] = v[13:0]; f4_wr++; end
   endtask

   task automatic add_seg(input bit w, input int p, input int c);
      if (w) begin
         for (int k = 0; k < 2; k++) begin e1_mem[e1_wr] = model(p, c, k, 1); e1_wr++; end
      end else begin
         for (int k = 0; k < 16; k++) begin e4_mem[e4_wr] = model(p, c, k, 4); e4_wr++; end
      end
   endtask

   // Pulse almost_full for one sampling edge and measure edges until the first valid output.
   task automatic prime(input bit w);
      int lat;
      @(negedge clk);
      if (w) af1 = 1'b1; else af4 = 1'b1;
      @(posedge clk);
      #1;
      af1 = 1'b0;
      af4 = 1'b0;
      lat = 0;
      while (!(w ? ov1 : ov4) && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check(w ? "latency1" : "latency4", lat, 4);
   endtask

   // Run until out_valid drops; underrun must already be flagged and the last sample held.
   task automatic wait_end(input bit w, input int hold);
      int n;
      logic ur_prev;
      n = 0;
      ur_prev = 1'b0;
      while ((w ? ov1 : ov4) && n < 300) begin
         ur_prev = w ? ur1 : ur4;
         @(negedge clk);
         n++;
      end
      check(w ? "run_end1" : "run_end4", int'(w ? ov1 : ov4), 0);
      check(w ? "underrun_edge1" : "underrun_edge4", int'(ur_prev), 1);
      check(w ? "underrun1" : "underrun4", int'(w ? ur1 : ur4), 1);
      check(w ? "hold1" : "hold4", int'(w ? id1 : id4), hold);
   endtask

   // Monitor: pops expected samples whenever a DUT presents one and watches read strobes.
   initial begin : monitor
      int cyc, last4, last1;
      cyc = 0;
      last4 = -100;
      last1 = -100;
      forever begin
         @(negedge clk);
         cyc++;
         if (ov4) begin
            if (e4_rd < e4_wr) begin
               check("sb4", int'(id4), e4_mem[e4_rd]);
               e4_rd++;
            end else begin
               check("sb4_unexpected", int'(id4), 32767);
            end
         end
         if (ov1) begin
            if (e1_rd < e1_wr) begin
               check("sb1", int'(id1), e1_mem[e1_rd]);
               e1_rd++;
            end else begin
               check("sb1_unexpected", int'(id1), 32767);
            end
         end
         if (rd4) begin
            rd_cnt4++;
            check("rd_on_empty4", int'(empty4), 0);
            if ((cyc - last4) <= 16 && (cyc - last4) != 1) check("rd_period4", cyc - last4, 16);
            last4 = cyc;
         end
         if (rd1) begin
            rd_cnt1++;
            check("rd_on_empty1", int'(empty1), 0);
            if ((cyc - last1) <= 2 && (cyc - last1) != 1) check("rd_period1", cyc - last1, 2);
            last1 = cyc;
         end
      end
   end

   initial begin : stimulus
      int r0;
      rst4 = 1'b1; rst1 = 1'b1; af4 = 1'b0; af1 = 1'b0;
      repeat (3) @(negedge clk);
      rst4 = 1'b0; rst1 = 1'b0;
      @(negedge clk);
      check("reset_id4", int'(id4), 0);
      check("reset_ov4", int'(ov4), 0);
      check("reset_ur4", int'(ur4), 0);
      check("reset_rd4", int'(rd4), 0);
      check("reset_ov1", int'(ov1), 0);

      // Ramp 0,160,320,480: three back-to-back segments, then underrun.
      add_sample(1'b0, 0); add_sample(1'b0, 160); add_sample(1'b0, 320); add_sample(1'b0, 480);
      add_seg(1'b0, 0, 160); add_seg(1'b0, 160, 320); add_seg(1'b0, 320, 480);
      prime(1'b0);
      wait_end(1'b0, 470);
      check("rd_count_ramp", rd_cnt4, 4);
      check("drain_ramp", e4_rd, e4_wr);

      // Re-prime after underrun with a small negative step; underrun stays set.
      repeat (4) @(negedge clk);
      add_sample(1'b0, 0); add_sample(1'b0, -3);
      for (int k = 0; k < 16; k++) begin e4_mem[e4_wr] = neg_tab[k]; e4_wr++; end
      prime(1'b0);
      check("underrun_sticky", int'(ur4), 1);
      wait_end(1'b0, -3);
      check("drain_neg", e4_rd, e4_wr);

      @(negedge clk); rst4 = 1'b1;
      @(negedge clk); rst4 = 1'b0;
      check("underrun_cleared", int'(ur4), 0);

      // Full-scale swing.
      add_sample(1'b0, -8192); add_sample(1'b0, 8191);
      add_seg(1'b0, -8192, 8191);
      prime(1'b0);
      wait_end(1'b0, 7167);
      check("drain_full", e4_rd, e4_wr);

      // Asynchronous reset at RUN phase 7: only outputs for phases 0..6 ever appear.
      repeat (3) @(negedge clk);
      add_sample(1'b0, 0); add_sample(1'b0, 160); add_sample(1'b0, 320);
      for (int k = 0; k < 7; k++) begin e4_mem[e4_wr] = model(0, 160, k, 4); e4_wr++; end
      prime(1'b0);
      repeat (6) @(negedge clk);
      #2 rst4 = 1'b1;
      #1;
      check("async_id4", int'(id4), 0);
      check("async_ov4", int'(ov4), 0);
      check("async_rd4", int'(rd4), 0);
      check("async_ur4", int'(ur4), 0);
      @(negedge clk); rst4 = 1'b0;
      r0 = rd_cnt4;
      repeat (10) @(negedge clk);
      check("idle_ov4", int'(ov4), 0);
      check("idle_reads4", rd_cnt4 - r0, 0);
      check("drain_rst", e4_rd, e4_wr);

      // RATE_LOG2=1: 0,4,8,12 -> 0,2,4,6,8,10.
      add_sample(1'b1, 0); add_sample(1'b1, 4); add_sample(1'b1, 8); add_sample(1'b1, 12);
      add_seg(1'b1, 0, 4); add_seg(1'b1, 4, 8); add_seg(1'b1, 8, 12);
      prime(1'b1);
      wait_end(1'b1, 10);
      check("rd_count1", rd_cnt1, 4);
      check("drain1", e1_rd, e1_wr);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
